// File: rtl/fpu_pkg.sv
// Shared single-precision constants, field helpers and the multiplier stage payloads.
package fpu_pkg;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam int MANT_W  = 23;
    localparam int ES_W    = 10;

    // Stage-1 payload: unpacked sign/flags, biased exponent sum, two partial products.
    typedef struct packed {
        logic                   sign;
        logic                   zero;
        logic                   inf;
        logic signed [ES_W-1:0] es;
        logic [35:0]            pp_lo;
        logic [35:0]            pp_hi;
    } s1_t;

    // Stage-2 payload: normalized 24b mantissa with guard and sticky for rounding.
    typedef struct packed {
        logic                   sign;
        logic                   zero;
        logic                   inf;
        logic signed [ES_W-1:0] es;
        logic [MANT_W:0]        mant;
        logic                   guard;
        logic                   sticky;
    } s2_t;

    function automatic logic f_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [7:0] f_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    // Mantissa with the hidden bit restored; only meaningful for normal inputs.
    function automatic logic [MANT_W:0] f_mant(input logic [31:0] x);
        return {1'b1, x[22:0]};
    endfunction

endpackage

// File: rtl/fmul_round_pack.sv
// Round-to-nearest-even, overflow/underflow clamping and IEEE packing of a
// normalized mantissa; purely combinational so it can sit in any final stage.
module fmul_round_pack
    import fpu_pkg::*;
(
    input  s2_t         i_s2,
    output logic [31:0] o_result
);

    logic                   w_up;
    logic [MANT_W+1:0]      w_mr;
    logic                   w_carry;
    logic [MANT_W:0]        w_mant;
    logic signed [ES_W-1:0] w_exp;

    assign w_up    = i_s2.guard && (i_s2.sticky || i_s2.mant[0]);
    assign w_mr    = {1'b0, i_s2.mant} + (MANT_W+2)'(w_up);
    assign w_carry = w_mr[MANT_W+1];
    // A carry out means the mantissa rolled over to exactly 2.0 -> 1.0 with exp+1.
    assign w_mant  = w_carry ? {1'b1, {MANT_W{1'b0}}} : w_mr[MANT_W:0];
    assign w_exp   = w_carry ? i_s2.es + 10'sd1 : i_s2.es;

    always_comb begin
        o_result = {i_s2.sign, w_exp[7:0], w_mant[MANT_W-1:0]};
        if (i_s2.inf) begin
            o_result = {i_s2.sign, 8'hFF, {MANT_W{1'b0}}};
        end else if (i_s2.zero) begin
            o_result = {i_s2.sign, 31'd0};
        end else if (w_exp >= ES_W'(EXP_MAX)) begin
            o_result = {i_s2.sign, 8'hFF, {MANT_W{1'b0}}};
        end else if (w_exp <= 10'sd0) begin
            o_result = {i_s2.sign, 31'd0};
        end
    end

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage pipelined single-precision multiplier with valid/ready on both
// sides, a tag travelling with each operation, and a synchronous flush.
module fmul_pipe
    import fpu_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      rs1,
    input  logic [31:0]      rs2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      rd,
    output logic [TAG_W-1:0] out_tag
);

    logic             w_adv;
    logic             r_v1, r_v2, r_v3;
    s1_t              w_s1, r_s1;
    s2_t              w_s2, r_s2;
    logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3;
    logic [31:0]      r_rd;
    logic [31:0]      w_res;

    logic [7:0]       w_e1, w_e2;
    logic [MANT_W:0]  w_ma, w_mb;
    logic [47:0]      w_p;

    // The whole pipe moves as one; bubbles are carried, never squeezed out.
    assign w_adv     = !r_v3 || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v3;
    assign rd        = r_rd;
    assign out_tag   = r_tag3;

    assign w_e1 = f_exp(rs1);
    assign w_e2 = f_exp(rs2);
    assign w_ma = f_mant(rs1);
    assign w_mb = f_mant(rs2);

    always_comb begin
        w_s1.sign  = f_sign(rs1) ^ f_sign(rs2);
        w_s1.zero  = (w_e1 == 8'd0) || (w_e2 == 8'd0);
        w_s1.inf   = ((w_e1 == 8'hFF) && (w_e2 != 8'd0)) ||
                     ((w_e2 == 8'hFF) && (w_e1 != 8'd0));
        w_s1.es    = ES_W'(w_e1) + ES_W'(w_e2) - ES_W'(BIAS);
        w_s1.pp_lo = 36'(w_ma) * 36'(w_mb[11:0]);
        w_s1.pp_hi = 36'(w_ma) * 36'(w_mb[23:12]);
    end

    assign w_p = 48'(r_s1.pp_lo) + {r_s1.pp_hi, 12'd0};

    always_comb begin
        w_s2.sign = r_s1.sign;
        w_s2.zero = r_s1.zero;
        w_s2.inf  = r_s1.inf;
        if (w_p[47]) begin
            w_s2.es     = r_s1.es + 10'sd1;
            w_s2.mant   = w_p[47:24];
            w_s2.guard  = w_p[23];
            w_s2.sticky = |w_p[22:0];
        end else begin
            w_s2.es     = r_s1.es;
            w_s2.mant   = w_p[46:23];
            w_s2.guard  = w_p[22];
            w_s2.sticky = |w_p[21:0];
        end
    end

    fmul_round_pack u_round_pack (
        .i_s2     (r_s2),
        .o_result (w_res)
    );

    // Flush wins over advance, so an input offered alongside it is dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (flush) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_rd   <= 32'd0;
            r_tag1 <= '0;
            r_tag2 <= '0;
            r_tag3 <= '0;
        end else if (w_adv) begin
            r_s1   <= w_s1;
            r_s2   <= w_s2;
            r_rd   <= w_res;
            r_tag1 <= in_tag;
            r_tag2 <= r_tag1;
            r_tag3 <= r_tag2;
        end
    end

endmodule

// File: tb/tb_fmul_pipe.sv
// Scoreboard bench for fmul_pipe: the driver queues expected products, a
// negedge monitor retires them as the pipe presents results.
module tb_fmul_pipe;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic [4:0]  in_tag = 5'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] rd;
    logic [4:0]  out_tag;

    fmul_pipe #(.TAG_W(5)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic [4:0]  tag;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: every retired product is compared with the oldest expectation.
    initial forever begin
        @(negedge clk);
        if (rstn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL unexpected_out: got rd=%h tag=%0d expected no output (cycle %0d)", rd, out_tag, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("retire tag=%0d rd=%h expected=%h cycle=%0d", out_tag, rd, e.rd, cyc);
                check("rd", rd, e.rd);
                check("out_tag", 32'(out_tag), 32'(e.tag));
                if (e.lat) check("latency", 32'(cyc - e.acc), 32'd3);
            end
        end
    end

    // One cycle of stimulus; an accepted op is queued only when keep is set.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, input logic [31:0] e, input bit lat,
                        input logic fl, input bit keep, output bit acc);
        in_valid = v;
        rs1      = a;
        rs2      = b;
        in_tag   = t;
        flush    = fl;
        @(negedge clk);
        acc = v && in_ready && !fl;
        if (acc && keep) begin
            sb.push_back('{rd: e, tag: t, acc: cyc, lat: lat});
            $display("issue  tag=%0d a=%h b=%h expected=%h cycle=%0d", t, a, b, e, cyc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] t,
                         input logic [31:0] e, input bit lat);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) step(1'b1, a, b, t, e, lat, 1'b0, 1'b1, acc);
        if (!acc) check("issue_accept", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) step(1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, acc);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(posedge clk);
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Independent reference: exact product in double precision, then RNE to single.
    function automatic real sp2r(input logic [31:0] x);
        logic [63:0] d;
        d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        int          e;
        logic [22:0] keep;
        logic [28:0] rem;
        logic [23:0] m;
        bit          up;
        d    = $realtobits(r);
        e    = int'(d[62:52]) - 1023 + 127;
        keep = d[51:29];
        rem  = d[28:0];
        up   = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && keep[0]);
        m    = {1'b0, keep} + 24'(up);
        if (m[23]) begin
            e++;
            m = 24'd0;
        end
        return {d[63], 8'(e), m[22:0]};
    endfunction

    logic [31:0] dir_a [7] = '{32'h40000000, 32'hC0000000, 32'h3F800001, 32'h3FC00000,
                               32'h00000000, 32'h7F000000, 32'h00800000};
    logic [31:0] dir_b [7] = '{32'h40400000, 32'h40400000, 32'h3F800001, 32'h3FC00000,
                               32'hC2000000, 32'h40000000, 32'h3F000000};
    logic [31:0] dir_e [7] = '{32'h40C00000, 32'hC0C00000, 32'h3F800002, 32'h40100000,
                               32'h80000000, 32'h7F800000, 32'h00000000};

    initial begin
        bit          acc;
        logic [31:0] a, b;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_rd", rd, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        rstn = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed products, back to back, fixed latency
        for (int i = 0; i < 7; i++) issue(dir_a[i], dir_b[i], 5'(i + 1), dir_e[i], 1'b1);
        drain();

        // Backpressure: three ops fill the pipe, the fourth is refused
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, dir_a[i + 1], dir_b[i + 1], 5'(i + 1), dir_e[i + 1], 1'b0, 1'b0, 1'b1, acc);
            check("bp_accept", 32'(acc), 32'd1);
        end
        in_valid = 1'b1;
        rs1      = dir_a[0];
        rs2      = dir_b[0];
        in_tag   = 5'd4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_hold_rd", rd, dir_e[1]);
            check("bp_hold_tag", 32'(out_tag), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        step(1'b1, dir_a[0], dir_b[0], 5'd4, dir_e[0], 1'b0, 1'b0, 1'b1, acc);
        check("bp_accept4", 32'(acc), 32'd1);
        // Results 1..4 must now retire on consecutive cycles.
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_drain_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
        end
        #1;
        drain();

        // Streaming of random normal operands, one per cycle
        for (int i = 0; i < 16; i++) begin
            a = {1'($urandom_range(0, 1)), 8'(100 + $urandom_range(0, 54)), 23'($urandom)};
            b = {1'($urandom_range(0, 1)), 8'(100 + $urandom_range(0, 54)), 23'($urandom)};
            issue(a, b, 5'(i + 10), r2sp(sp2r(a) * sp2r(b)), 1'b1);
        end
        drain();

        // Flush with three ops stalled in the pipe and a fourth offered
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, dir_a[i], dir_b[i], 5'(i + 1), 32'd0, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, dir_a[3], dir_b[3], 5'd4, 32'd0, 1'b0, 1'b1, 1'b0, acc);
        out_ready = 1'b1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            check("flush_quiet", 32'(out_valid), 32'd0);
        end
        issue(dir_a[3], dir_b[3], 5'd7, dir_e[3], 1'b1);
        drain();

        // Flush coinciding with an accepted handshake
        step(1'b1, dir_a[0], dir_b[0], 5'd1, 32'd0, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, dir_a[1], dir_b[1], 5'd2, 32'd0, 1'b0, 1'b1, 1'b0, acc);
        check("flush2_out_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            check("flush2_quiet", 32'(out_valid), 32'd0);
        end
        issue(dir_a[2], dir_b[2], 5'd9, dir_e[2], 1'b1);
        drain();

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) issue(dir_a[i], dir_b[i], 5'(i + 1), dir_e[i], 1'b1);
        #1;
        rstn = 1'b0;
        sb.delete();
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_rd", rd, 32'd0);
        check("arst_out_tag", 32'(out_tag), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            idle(1);
            check("arst_quiet", 32'(out_valid), 32'd0);
        end
        issue(dir_a[5], dir_b[5], 5'd21, dir_e[5], 1'b1);
        issue(dir_a[6], dir_b[6], 5'd22, dir_e[6], 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
